// File: rtl/coding_sequencer_if.sv
// Signal bundle for coding_sequencer: nibble/strobe inputs, seven-segment and status outputs.
// Handshake: ready and play are edge strobes (only a 0->1 change is acted on) and there is no
// backpressure; a strobe the block cannot accept is dropped, and clear is a level that wins over both.
interface coding_sequencer_if;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       ready;
  logic       play;
  logic       clear;
  logic [6:0] dse;
  logic [6:0] dsd;
  logic       busy;
  logic       full;
  logic [2:0] count;
  logic [1:0] state_dbg;

  modport master (
    output a, b, c, d, ready, play, clear,
    input  dse, dsd, busy, full, count, state_dbg
  );

  modport slave (
    input  a, b, c, d, ready, play, clear,
    output dse, dsd, busy, full, count, state_dbg
  );
endinterface

// File: rtl/coding_sequencer.sv
// Buffers up to four nibbles, then plays them back as encoded two-digit codes on a pair of
// seven-segment displays, each symbol held for HOLD_CYCLES clocks.
module coding_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_LEN     = 4
) (
  input logic               clk,
  input logic               reset,
  coding_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0] LEN         = 3'(MAX_LEN);
  localparam logic [6:0] SEG_BLANK   = 7'b0000000;
  localparam logic [6:0] SEG_DASH    = 7'b0000001;

  function automatic logic [3:0] encode(input logic [3:0] n);
    logic [3:0] code;
    case (n)
      4'd0:    code = 4'd10;
      4'd1:    code = 4'd3;
      4'd2:    code = 4'd9;
      4'd3:    code = 4'd0;
      4'd4:    code = 4'd8;
      4'd5:    code = 4'd15;
      4'd6:    code = 4'd2;
      4'd7:    code = 4'd13;
      4'd8:    code = 4'd14;
      4'd9:    code = 4'd12;
      4'd10:   code = 4'd11;
      4'd11:   code = 4'd4;
      4'd12:   code = 4'd7;
      4'd13:   code = 4'd1;
      4'd14:   code = 4'd6;
      default: code = 4'd5;
    endcase
    return code;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] dgt);
    logic [6:0] pat;
    case (dgt)
      4'd0:    pat = 7'b1111110;
      4'd1:    pat = 7'b0110000;
      4'd2:    pat = 7'b1101101;
      4'd3:    pat = 7'b1111001;
      4'd4:    pat = 7'b0110011;
      4'd5:    pat = 7'b1011011;
      4'd6:    pat = 7'b1011111;
      4'd7:    pat = 7'b1110000;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1111011;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] timer_q, timer_d;
  logic       ready_q, play_q;
  logic       wr_en;
  logic [3:0] sym_buf [MAX_LEN];

  logic [3:0] nibble;
  logic       ready_rise, play_rise;
  logic [3:0] disp_code;
  logic [6:0] dse_d, dsd_d;

  assign nibble     = {bus.a, bus.b, bus.c, bus.d};
  assign ready_rise = bus.ready & ~ready_q;
  assign play_rise  = bus.play & ~play_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    wr_en   = 1'b0;
    if (bus.clear) begin
      state_d = LOAD;
      count_d = 3'd0;
      idx_d   = 2'd0;
      timer_d = 8'd0;
    end else begin
      case (state_q)
        LOAD: begin
          // play is checked first so a same-cycle ready rise is dropped
          if (play_rise && count_q != 3'd0) begin
            state_d = PLAY;
            idx_d   = 2'd0;
            timer_d = HOLD_RELOAD;
          end else if (ready_rise && count_q < LEN) begin
            wr_en   = 1'b1;
            count_d = count_q + 3'd1;
          end
        end
        PLAY: begin
          if (timer_q == 8'd0) begin
            if ({1'b0, idx_q} == count_q - 3'd1) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 2'd1;
              timer_d = HOLD_RELOAD;
            end
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        DONE: begin
          if (play_rise) begin
            state_d = PLAY;
            idx_d   = 2'd0;
            timer_d = HOLD_RELOAD;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_comb begin
    disp_code = encode(sym_buf[idx_q]);
    dse_d     = SEG_BLANK;
    dsd_d     = seg({1'b0, count_q});
    case (state_q)
      PLAY: begin
        if (disp_code >= 4'd10) begin
          dse_d = seg(4'd1);
          dsd_d = seg(disp_code - 4'd10);
        end else begin
          dsd_d = seg(disp_code);
        end
      end
      DONE: begin
        dse_d = SEG_DASH;
        dsd_d = SEG_DASH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD;
      count_q <= 3'd0;
      idx_q   <= 2'd0;
      timer_q <= 8'd0;
      ready_q <= 1'b0;
      play_q  <= 1'b0;
      bus.busy <= 1'b0;
      bus.full <= 1'b0;
      bus.dse  <= SEG_BLANK;
      bus.dsd  <= 7'b1111110;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      ready_q <= bus.ready;
      play_q  <= bus.play;
      // display/status trail the state registers by one clock
      bus.busy <= (state_q == PLAY);
      bus.full <= (count_q == LEN);
      bus.dse  <= dse_d;
      bus.dsd  <= dsd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) sym_buf[count_q[1:0]] <= nibble;
  end

  assign bus.count     = count_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_coding_sequencer.sv
// Directed bench for coding_sequencer: load, playback, full, priority, clear and reset cases.
module tb_coding_sequencer;
  localparam logic [6:0] BLANK = 7'b0000000;
  localparam logic [6:0] DASH  = 7'b0000001;
  localparam logic [6:0] D0 = 7'b1111110, D1 = 7'b0110000, D2 = 7'b1101101, D3 = 7'b1111001;
  localparam logic [6:0] D4 = 7'b0110011, D5 = 7'b1011011, D7 = 7'b1110000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   passed = 0;
  int   total  = 0;
  logic [6:0] exp_seq [4];

  coding_sequencer_if bus ();

  coding_sequencer #(.HOLD_CYCLES(4), .MAX_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load(input logic [3:0] n);
    {bus.a, bus.b, bus.c, bus.d} = n;
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    tick();
  endtask

  task automatic pulse_play();
    bus.play = 1'b1;
    tick();
    bus.play = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
  endtask

  initial begin
    {bus.a, bus.b, bus.c, bus.d} = 4'd0;
    bus.ready = 1'b0;
    bus.play  = 1'b0;
    bus.clear = 1'b0;

    // reset values
    tick();
    tick();
    reset = 1'b1;
    check("rst_busy", bus.busy, 0);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_dse", bus.dse, BLANK);
    check("rst_dsd", bus.dsd, D0);
    check("rst_state", bus.state_dbg, 0);

    // single symbol 0 -> code 10
    load(4'd0);
    check("l1_count", bus.count, 1);
    check("l1_dsd", bus.dsd, D1);
    pulse_play();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("p1_busy", bus.busy, 1);
      check("p1_dse", bus.dse, D1);
      check("p1_dsd", bus.dsd, D0);
    end
    tick();
    check("p1_done_busy", bus.busy, 0);
    check("p1_done_dse", bus.dse, DASH);
    check("p1_done_dsd", bus.dsd, DASH);
    check("p1_done_state", bus.state_dbg, 2);

    // ready in DONE ignored, then clear
    load(4'd3);
    check("done_ready_count", bus.count, 1);
    do_clear();
    check("clr_count", bus.count, 0);
    check("clr_dsd", bus.dsd, D0);
    check("clr_state", bus.state_dbg, 0);

    // four symbols, then a fifth ready that must be dropped
    load(4'd1);
    load(4'd6);
    load(4'd15);
    load(4'd12);
    check("full_count", bus.count, 4);
    check("full_flag", bus.full, 1);
    check("full_dsd", bus.dsd, D4);
    load(4'd3);
    check("over_count", bus.count, 4);
    check("over_full", bus.full, 1);
    check("over_dsd", bus.dsd, D4);

    exp_seq[0] = D3;
    exp_seq[1] = D2;
    exp_seq[2] = D5;
    exp_seq[3] = D7;
    pulse_play();
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        check("p4_busy", bus.busy, 1);
        check("p4_dse", bus.dse, BLANK);
        check("p4_dsd", bus.dsd, exp_seq[s]);
      end
    end
    tick();
    check("p4_done_busy", bus.busy, 0);
    check("p4_done_dsd", bus.dsd, DASH);

    // replay from DONE keeps the buffer
    pulse_play();
    tick();
    check("replay_busy", bus.busy, 1);
    check("replay_dsd", bus.dsd, D3);
    check("replay_count", bus.count, 4);
    do_clear();

    // simultaneous ready and play with one stored symbol
    load(4'd0);
    {bus.a, bus.b, bus.c, bus.d} = 4'd5;
    bus.ready = 1'b1;
    bus.play  = 1'b1;
    tick();
    bus.ready = 1'b0;
    bus.play  = 1'b0;
    check("sim_count", bus.count, 1);
    check("sim_state", bus.state_dbg, 1);
    tick();
    check("sim_busy", bus.busy, 1);
    check("sim_dse", bus.dse, D1);
    check("sim_dsd", bus.dsd, D0);
    do_clear();

    // clear during the second symbol
    load(4'd1);
    load(4'd6);
    pulse_play();
    for (int k = 0; k < 5; k++) tick();
    check("mid_dsd", bus.dsd, D2);
    check("mid_busy", bus.busy, 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("abort_count", bus.count, 0);
    check("abort_state", bus.state_dbg, 0);
    tick();
    check("abort_busy", bus.busy, 0);
    check("abort_dse", bus.dse, BLANK);
    check("abort_dsd", bus.dsd, D0);

    // reset mid-playback, reload, play to DONE, replay from idx 0
    load(4'd0);
    pulse_play();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst_busy", bus.busy, 0);
    check("mrst_full", bus.full, 0);
    check("mrst_count", bus.count, 0);
    check("mrst_dse", bus.dse, BLANK);
    check("mrst_dsd", bus.dsd, D0);
    check("mrst_state", bus.state_dbg, 0);
    load(4'd15);
    load(4'd12);
    pulse_play();
    tick();
    check("rl_dsd0", bus.dsd, D5);
    for (int k = 0; k < 8; k++) tick();
    check("rl_done", bus.dsd, DASH);
    check("rl_done_busy", bus.busy, 0);
    pulse_play();
    tick();
    check("rl_replay_busy", bus.busy, 1);
    check("rl_replay_dse", bus.dse, BLANK);
    check("rl_replay_dsd", bus.dsd, D5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/coding_sequencer.md
CODING_SEQUENCER -- requirements
Module: coding_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, SHALL set the clock cycles each encoded symbol is displayed during playback (legal range 1..255).
REQ-002 Parameter MAX_LEN, default 4, SHALL set the symbol buffer depth (fixed at 4 for this block).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset (reset=0 sampled at a clk edge resets the block).
REQ-005 a, b, c, d  input  1 each  SHALL form the input nibble {a,b,c,d}, with a as the MSB.
REQ-006 ready  input  1  SHALL be the load strobe; only its rising edge is acted on.
REQ-007 play  input  1  SHALL be the playback start; only its rising edge is acted on.
REQ-008 clear  input  1  SHALL be a level-sensitive buffer clear and abort.
REQ-009 dse  output  7  SHALL drive the left (tens) display; segments {a,b,c,d,e,f,g} on bits 6..0, active-high.
REQ-010 dsd  output  7  SHALL drive the right (units) display, in the same format as dse.
REQ-011 busy  output  1  SHALL be high while state is PLAY.
REQ-012 full  output  1  SHALL be high when count == MAX_LEN.
REQ-013 count  output  3  SHALL hold the number of stored symbols (0..4).

Function
REQ-014 Edge detection: ready_q and play_q SHALL be registered copies of the inputs. rise = in & ~in_q.
REQ-015 Encoding table (input -> code) SHALL be: 0->10, 1->3, 2->9, 3->0, 4->8, 5->15, 6->2, 7->13, 8->14, 9->12, 10->11, 11->4, 12->7, 13->1, 14->6, 15->5.
REQ-016 Digit patterns SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. BLANK=0000000, DASH=0000001.
REQ-017 Encoded code SHALL be split into tens (code/10) and units (code%10). The tens digit SHALL show BLANK when code<10.
REQ-018 The FSM SHALL have three states: LOAD, PLAY, DONE.
REQ-019 LOAD, on ready rise with count<MAX_LEN: the block SHALL store {a,b,c,d} at buf[count] and set count=count+1.
REQ-020 LOAD, ready rise with full=1: the block SHALL ignore it (no write, count unchanged).
REQ-021 LOAD, play rise with count>0: the block SHALL go to PLAY with idx=0 and timer=HOLD_CYCLES-1.
REQ-022 LOAD, play rise with count==0: the block SHALL ignore it.
REQ-023 LOAD, simultaneous ready rise and play rise: play SHALL take priority and the nibble SHALL NOT be stored.
REQ-024 PLAY: timer SHALL decrement each cycle. At timer==0:
- if idx==count-1, the block SHALL go to DONE;
- otherwise idx SHALL increment and timer SHALL reload HOLD_CYCLES-1.
REQ-025 Symbol dwell: each symbol SHALL be displayed for exactly HOLD_CYCLES cycles.
REQ-026 DONE, on play rise: the block SHALL replay (PLAY, idx=0, timer reloaded) with the buffer kept.
REQ-027 Ready rises in PLAY or DONE SHALL be ignored.
REQ-028 clear=1 in any state SHALL force LOAD, count=0 and idx=0 at the next edge, with priority over ready and play. Buffer contents SHALL be don't-care after clear.
REQ-029 Outputs SHALL be registered and SHALL reflect the state and index one cycle after the edge that changed them.
REQ-030 Display content per state:
- LOAD: dse=BLANK, dsd=digit(count).
- PLAY: encoded buf[idx].
- DONE: dse=dsd=DASH.

Reset
REQ-031 On reset=0 the block SHALL set: state=LOAD, count=0, idx=0, timer=0, ready_q=play_q=0, busy=0, full=0, dse=BLANK, dsd=digit 0 (1111110).
REQ-032 Reset mid-PLAY SHALL abort playback and discard the buffer, and outputs SHALL take reset values one cycle later.

Verification
REQ-033 Reset, then load nibble 0000 and play -> dse=0110000 and dsd=1111110 ("10") for 4 cycles, then DASH/DASH, busy falls.
REQ-034 Load 0001, 0110, 1111, 1100, then play -> displays sequence 3, 2, 5, 7 with tens BLANK, each held 4 cycles, total 16 busy cycles.
REQ-035 Load 4 symbols, fifth ready rise -> count stays 4, full=1, dsd=0110011.
REQ-036 In LOAD with count=1, ready and play rise in the same cycle -> PLAY entered, count stays 1.
REQ-037 In PLAY at idx=1, assert clear -> next cycle LOAD, count=0, busy=0, dse=BLANK, dsd=1111110.
REQ-038 In PLAY, reset=0 for one cycle -> all outputs at REQ-031 values. Then DONE replay via a play rise after a reload -> playback restarts from idx=0.
